// File: rtl/router_port_tx.sv
// router_port_tx: serialises one (address, payload) request onto the
// valid/stream pair of a router input port.
//   Frame: START (valid=1, stream=0), 3 address bits, PAYLOAD_W payload bits,
//   all MSB first, then GAP_CYCLES idle cycles with valid=0.
// Ports:
//   clk, rst        clock / asynchronous active-high reset
//   req_valid/ready request handshake (ready decoded from IDLE)
//   req_addr/data   destination port and payload, captured on acceptance
//   valid, stream   registered frame strobe and serial bit
//   busy            registered, high from START through the last GAP cycle
//   done            registered 1-cycle pulse in the first GAP cycle
//   pkt_count       registered count of completed frames, wraps silently
module router_port_tx #(
  parameter int PAYLOAD_W  = 8,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_addr,
  input  logic [PAYLOAD_W-1:0] req_data,
  output logic                 valid,
  output logic                 stream,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     pkt_count
);

  localparam int FW   = 3 + PAYLOAD_W;
  localparam int M1   = (PAYLOAD_W > 3) ? PAYLOAD_W : 3;
  // One counter serves address, payload and gap phases.
  localparam int BMAX = (GAP_CYCLES > M1) ? GAP_CYCLES : M1;
  localparam int CW   = $clog2(BMAX);

  localparam logic [CW-1:0] ADDR_LAST = CW'(2);
  localparam logic [CW-1:0] DATA_LAST = CW'(PAYLOAD_W - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, ADDR, DATA, GAP} state_t;

  state_t        state, state_n;
  logic [FW-1:0] frame_sh, frame_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          valid_n, stream_n, busy_n, done_n, count_inc, accept;

  assign req_ready = (state == IDLE);

  // Outputs are registered: this block computes the values they take in
  // the next cycle. Address and payload share one shift register, so the
  // payload MSB follows the last address bit without extra muxing.
  always_comb begin
    state_n   = state;
    frame_n   = frame_sh;
    cnt_n     = cnt;
    valid_n   = 1'b0;
    stream_n  = 1'b0;
    busy_n    = 1'b1;
    done_n    = 1'b0;
    count_inc = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        accept = req_valid;
      end
      START: begin
        state_n  = ADDR;
        cnt_n    = '0;
        valid_n  = 1'b1;
        stream_n = frame_sh[FW-1];
        frame_n  = {frame_sh[FW-2:0], 1'b0};
      end
      ADDR: begin
        valid_n  = 1'b1;
        stream_n = frame_sh[FW-1];
        frame_n  = {frame_sh[FW-2:0], 1'b0};
        if (cnt == ADDR_LAST) begin
          state_n = DATA;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == DATA_LAST) begin
          state_n   = GAP;
          cnt_n     = '0;
          done_n    = 1'b1;
          count_inc = 1'b1;
        end else begin
          valid_n  = 1'b1;
          stream_n = frame_sh[FW-1];
          frame_n  = {frame_sh[FW-2:0], 1'b0};
          cnt_n    = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          // A held request is taken on the edge leaving the last gap cycle,
          // so frames run back to back with exactly GAP_CYCLES idle cycles.
          // The requester sees the acceptance as valid rising (START).
          if (req_valid) begin
            accept = 1'b1;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
    if (accept) begin
      state_n = START;
      frame_n = {req_addr, req_data};
      cnt_n   = '0;
      valid_n = 1'b1;
      busy_n  = 1'b1;
      done_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      frame_sh  <= '0;
      cnt       <= '0;
      valid     <= 1'b0;
      stream    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pkt_count <= '0;
    end else begin
      state    <= state_n;
      frame_sh <= frame_n;
      cnt      <= cnt_n;
      valid    <= valid_n;
      stream   <= stream_n;
      busy     <= busy_n;
      done     <= done_n;
      if (count_inc) pkt_count <= pkt_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_router_port_tx.sv
// Bench for router_port_tx: a table of single frames, hand-written
// back-to-back / mid-frame reset / counter wrap sequences, and a randomized
// run against a cycle-position model of the frame timeline.
module tb_router_port_tx;

  localparam int PW  = 8;
  localparam int GAP = 1;

  logic       clk, rst, req_valid;
  logic [2:0] req_addr;
  logic [7:0] req_data;
  logic       req_ready, valid, stream, busy, done;
  logic [15:0] pkt_count;
  logic       req_ready4, valid4, stream4, busy4, done4;
  logic [3:0] pkt_count4;

  router_port_tx #(.PAYLOAD_W(PW), .GAP_CYCLES(GAP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .valid(valid), .stream(stream),
    .busy(busy), .done(done), .pkt_count(pkt_count));

  // Narrow-counter copy sharing all inputs, for the wrap behaviour.
  router_port_tx #(.PAYLOAD_W(PW), .GAP_CYCLES(GAP), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4),
    .req_addr(req_addr), .req_data(req_data), .valid(valid4), .stream(stream4),
    .busy(busy4), .done(done4), .pkt_count(pkt_count4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0]  a;
    logic [7:0]  d;
    logic [10:0] bits;
    bit          chg;
  } vec_t;

  vec_t tbl[10];

  // Starts in IDLE at a negedge, sends one frame, ends in IDLE at a negedge.
  task automatic run_frame(input logic [2:0] a, input logic [7:0] d,
                           input logic [10:0] exp_bits, input bit chg);
    logic [10:0] got;
    int hi;
    got = '0;
    chk("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_addr = a; req_data = d;
    @(negedge clk);
    chk("start", {valid, stream, busy, req_ready}, 4'b1010);
    req_valid = 1'b0;
    req_addr  = ~a;
    if (chg) req_data = ~d;
    hi = 1;
    for (int i = 0; i < 3 + PW; i++) begin
      @(negedge clk);
      got = {got[9:0], stream};
      if (valid) hi++;
    end
    chk("frame_bits", got, exp_bits);
    chk("valid_len", hi, 4 + PW);
    @(negedge clk);
    chk("gap", {valid, stream, busy, done}, 4'b0011);
    @(negedge clk);
    chk("back_idle", {valid, busy, done, req_ready}, 4'b0001);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  ra;
    logic [7:0]  rd;
    logic [10:0] pk [3];
    int rises, last_rise, ready_bad, prev_v;
    int fs, p, cnt_m;
    bit pend, ok;
    logic [10:0] fb;
    logic [4:0]  exp_o;

    tbl[0] = '{3'd5, 8'hA5, 11'b101_10100101, 1'b0};
    tbl[1] = '{3'd0, 8'h00, 11'b000_00000000, 1'b0};
    tbl[2] = '{3'd1, 8'h3C, 11'b001_00111100, 1'b1};
    tbl[3] = '{3'd2, 8'h81, 11'b010_10000001, 1'b0};
    tbl[4] = '{3'd3, 8'hFF, 11'b011_11111111, 1'b1};
    tbl[5] = '{3'd4, 8'h5A, 11'b100_01011010, 1'b0};
    tbl[6] = '{3'd6, 8'hC3, 11'b110_11000011, 1'b1};
    tbl[7] = '{3'd7, 8'h96, 11'b111_10010110, 1'b0};
    tbl[8] = '{3'd7, 8'hFF, 11'b111_11111111, 1'b0};
    tbl[9] = '{3'd0, 8'h01, 11'b000_00000001, 1'b1};

    req_valid = 1'b0; req_addr = '0; req_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_out", {req_ready, valid, stream, busy, done}, 5'b10000);
    chk("reset_cnt", pkt_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single frames, including all 8 addresses and payload changes while busy.
    for (int i = 0; i < 10; i++) begin
      run_frame(tbl[i].a, tbl[i].d, tbl[i].bits, tbl[i].chg);
      if (i == 0) chk("first_count", pkt_count, 1);
    end
    chk("table_count", pkt_count, 10);
    chk("table_count4", pkt_count4, 10);

    // Back-to-back: req_valid held high across three frames.
    pk[0] = {3'd6, 8'h11}; pk[1] = {3'd1, 8'hEE}; pk[2] = {3'd4, 8'h70};
    rises = 0; last_rise = 0; ready_bad = 0; prev_v = 0;
    req_valid = 1'b1; {req_addr, req_data} = pk[0];
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (req_ready !== !busy) ready_bad++;
      if (valid && !prev_v) begin
        rises++;
        if (rises > 1) chk("b2b_period", c - last_rise, 4 + PW + GAP);
        last_rise = c;
        if (rises < 3) {req_addr, req_data} = pk[rises];
        else req_valid = 1'b0;
      end
      prev_v = valid;
    end
    chk("b2b_rises", rises, 3);
    chk("b2b_ready_only_idle", ready_bad, 0);
    chk("b2b_count", pkt_count, 13);

    // Asynchronous reset while payload bit 3 is on the wire.
    req_valid = 1'b1; req_addr = 3'd3; req_data = 8'h5A;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst_bit3", {valid, stream, busy}, 3'b111);
    #1 rst = 1'b1;
    #1 chk("async_rst", {valid, stream, busy, done}, 4'b0000);
    chk("async_rst_cnt", pkt_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(3'd2, 8'h3C, 11'b010_00111100, 1'b0);
    chk("post_rst_count", pkt_count, 1);

    // Counter wrap on the 4-bit instance.
    rst = 1'b1; #1 rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      ra = 3'($urandom_range(0, 7));
      rd = 8'($urandom_range(0, 255));
      run_frame(ra, rd, {ra, rd}, 1'b0);
      if (i == 14) chk("wrap_15", pkt_count4, 15);
      if (i == 15) chk("wrap_0", pkt_count4, 0);
    end
    chk("wrap_end4", pkt_count4, 1);
    chk("wrap_end16", pkt_count, 17);

    // Randomized traffic against a frame-position model: a frame accepted
    // at the end of cycle fs-1 occupies positions 0..3+PW with valid high,
    // then GAP gap positions; a new frame may be taken when idle or at the
    // last gap position.
    rst = 1'b1; #1 rst = 1'b0;
    fs = -1000; pend = 0; cnt_m = 0; fb = '0; ra = '0; rd = '0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      p = k - fs;
      if (p < 0 || p >= 4 + PW + GAP) exp_o = 5'b10000;
      else if (p == 0)               exp_o = 5'b01010;
      else if (p < 4 + PW)           exp_o = {2'b01, fb[3 + PW - p], 2'b10};
      else                           exp_o = {4'b0001, p == 4 + PW};
      if (p == 4 + PW) cnt_m++;
      chk("rand_out", {req_ready, valid, stream, busy, done}, exp_o);
      chk("rand_out4", {req_ready4, valid4, stream4, busy4, done4}, exp_o);
      chk("rand_cnt", pkt_count, cnt_m);
      chk("rand_cnt4", pkt_count4, cnt_m % 16);
      ok = (p < 0) || (p >= 3 + PW + GAP);
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1;
        ra = 3'($urandom_range(0, 7));
        rd = 8'($urandom_range(0, 255));
      end
      req_valid = pend;
      req_addr  = pend ? ra : 3'($urandom_range(0, 7));
      req_data  = pend ? rd : 8'($urandom_range(0, 255));
      if (pend && ok) begin
        fs = k + 1;
        fb = {ra, rd};
        pend = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
